pc_jump: RTL and testbench

- Program-counter stage that sits directly downstream of the 16-way OR zero detector in the CPU datapath.
- Consumes the ALU result word and reduces it to zr (inverted 16-way OR) and ng (sign bit).
- Evaluates the C-instruction jump bits against zr/ng and either loads the A-register target or increments the PC.
- Also detects the canonical "jump-to-self" halt loop and freezes the PC until reset.

---
 rtl/pc_jump.sv | 205 ++++++++++++++++++++
 tb/tb_pc_jump.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_jump.sv
`default_nettype none
// ============================================================================
//  Module   : pc_jump (with gate library pc_nand2, pc_not, pc_and2, pc_or2,
//             or16way)
//  Purpose  : Program-counter stage. Reduces the ALU result to zr/ng, evaluates
//             the C-instruction jump bits, then loads the jump target or
//             increments. A taken jump to the current PC is the canonical halt
//             loop. It freezes the PC until reset.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Base gate: 2-input NAND. Every other gate below is built from it.
// ----------------------------------------------------------------------------
module pc_nand2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

// ----------------------------------------------------------------------------
// Inverter: a NAND with both inputs tied together.
// ----------------------------------------------------------------------------
module pc_not (
    input  logic a,
    output logic y
);
    pc_nand2 u_nand (.a(a), .b(a), .y(y));
endmodule

// ----------------------------------------------------------------------------
// 2-input AND: a NAND followed by an inverter.
// ----------------------------------------------------------------------------
module pc_and2 (
    input  logic a,
    input  logic b,
    output logic y
);
    logic nand_y;

    pc_nand2 u_nand (.a(a), .b(b), .y(nand_y));
    pc_not   u_inv  (.a(nand_y), .y(y));
endmodule

// ----------------------------------------------------------------------------
// 2-input OR: a NAND of the inverted inputs (De Morgan).
// ----------------------------------------------------------------------------
module pc_or2 (
    input  logic a,
    input  logic b,
    output logic y
);
    logic a_n;
    logic b_n;

    pc_not   u_inv_a (.a(a), .y(a_n));
    pc_not   u_inv_b (.a(b), .y(b_n));
    pc_nand2 u_nand  (.a(a_n), .b(b_n), .y(y));
endmodule

// ----------------------------------------------------------------------------
// 16-way OR. A balanced tree of OR2 gates, four levels deep.
// ----------------------------------------------------------------------------
module or16way (
    input  logic [15:0] in,
    output logic        out
);
    logic [7:0] lvl1;
    logic [3:0] lvl2;
    logic [1:0] lvl3;

    generate
        for (genvar i = 0; i < 8; i++) begin : g_lvl1
            pc_or2 u_or (.a(in[2*i]), .b(in[2*i+1]), .y(lvl1[i]));
        end
        for (genvar i = 0; i < 4; i++) begin : g_lvl2
            pc_or2 u_or (.a(lvl1[2*i]), .b(lvl1[2*i+1]), .y(lvl2[i]));
        end
        for (genvar i = 0; i < 2; i++) begin : g_lvl3
            pc_or2 u_or (.a(lvl2[2*i]), .b(lvl2[2*i+1]), .y(lvl3[i]));
        end
    endgenerate

    pc_or2 u_or_root (.a(lvl3[0]), .b(lvl3[1]), .y(out));
endmodule

// ----------------------------------------------------------------------------
// Program counter with conditional jump and halt-loop detection.
// ----------------------------------------------------------------------------
module pc_jump #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] aluout,
    input  logic [WIDTH-1:0] jaddr,
    input  logic [2:0]       j,
    input  logic             cinst,
    input  logic             hold,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             jumped,
    output logic             halted
);
    // The zero reduction is built from 16-bit slices so that any WIDTH works.
    // Unused upper bits of the last slice are padded with zeros.
    localparam int NCHUNK = (WIDTH + 15) / 16;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]          state;
    logic [NCHUNK*16-1:0] alu_padded;
    logic [NCHUNK-1:0]   chunk_any;
    logic                alu_any;
    logic                ng_n;
    logic                ps;
    logic                hit_lt;
    logic                hit_eq;
    logic                hit_gt;
    logic                hit_le;
    logic                hit_any;
    logic                take;
    logic                self_jump;

    // Zero-extend the ALU result to a whole number of 16-bit slices.
    always_comb begin
        alu_padded             = '0;
        alu_padded[WIDTH-1:0]  = aluout;
    end

    generate
        for (genvar c = 0; c < NCHUNK; c++) begin : g_zero_slice
            or16way u_or16 (
                .in  (alu_padded[c*16 +: 16]),
                .out (chunk_any[c])
            );
        end
    endgenerate

    // With the default WIDTH this is a single bit. Wider words merge the slices.
    assign alu_any = |chunk_any;

    // Flags: zr is the inverted OR-reduction and ng is the sign bit.
    // ps means strictly positive (non-zero and non-negative).
    pc_not  u_zr_inv (.a(alu_any), .y(zr));
    assign ng = aluout[WIDTH-1];
    pc_not  u_ng_inv (.a(ng), .y(ng_n));
    pc_and2 u_ps     (.a(alu_any), .b(ng_n), .y(ps));

    // Jump condition: j[2]=lt, j[1]=eq, j[0]=gt. The result is gated by cinst.
    pc_and2 u_hit_lt (.a(j[2]), .b(ng), .y(hit_lt));
    pc_and2 u_hit_eq (.a(j[1]), .b(zr), .y(hit_eq));
    pc_and2 u_hit_gt (.a(j[0]), .b(ps), .y(hit_gt));
    pc_or2  u_hit_le (.a(hit_lt), .b(hit_eq), .y(hit_le));
    pc_or2  u_hit    (.a(hit_le), .b(hit_gt), .y(hit_any));
    pc_and2 u_take   (.a(cinst), .b(hit_any), .y(take));

    // A taken jump whose target is the current PC is the idle loop.
    assign self_jump = (jaddr == out);

    // PC register and state machine. Reset is asynchronous and has the highest priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_RUN;
            out    <= '0;
            jumped <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hold) begin
                        // Stall: every register keeps its value, including jumped.
                        state <= ST_RUN;
                    end else if (take && self_jump) begin
                        state  <= ST_HALT;
                        jumped <= 1'b1;
                        halted <= 1'b1;
                    end else if (take) begin
                        out    <= jaddr;
                        jumped <= 1'b1;
                    end else begin
                        out    <= out + WIDTH'(1);
                        jumped <= 1'b0;
                    end
                end
                ST_HALT: begin
                    // Terminal state. Only reset leaves it.
                    jumped <= 1'b0;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= ST_RUN;
                    jumped <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_pc_jump.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_jump
//  Purpose  : Self-checking bench for pc_jump. Expected PC/flag values are
//             queued before each edge, then popped and compared after it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_jump;
    typedef struct {
        logic [15:0] pc;
        logic        jmp;
        logic        hlt;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] aluout;
    logic [15:0] jaddr;
    logic [2:0]  j;
    logic        cinst;
    logic        hold;
    logic [15:0] out;
    logic        zr;
    logic        ng;
    logic        jumped;
    logic        halted;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    pc_jump #(.WIDTH(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .aluout (aluout),
        .jaddr  (jaddr),
        .j      (j),
        .cinst  (cinst),
        .hold   (hold),
        .out    (out),
        .zr     (zr),
        .ng     (ng),
        .jumped (jumped),
        .halted (halted)
    );

    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads the PC by an unconditional jump (target must differ from the current PC).
    task automatic set_pc(input logic [15:0] v);
        cinst = 1'b1; j = 3'b111; jaddr = v; hold = 1'b0;
        tick();
        cinst = 1'b0; j = 3'b000;
    endtask

    task automatic test_reset();
        reset = 1'b1; aluout = '0; jaddr = '0; j = '0; cinst = 1'b0; hold = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({out, jumped, halted} !== {16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_init: out=%h jumped=%b halted=%b, required 0000 0 0", out, jumped, halted);
        end
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) exp_q.push_back('{16'(i), 1'b0, 1'b0, "count"});
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({out, jumped, halted} !== {e.pc, e.jmp, e.hlt}) begin
                n_fail++;
                $display("FAIL %s: out=%h jumped=%b halted=%b, required %h %b %b", e.tag, out, jumped, halted, e.pc, e.jmp, e.hlt);
            end
        end
        // Assert reset mid-cycle. The clear must take effect before any edge.
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if ({out, jumped, halted} !== {16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: out=%h jumped=%b halted=%b, required 0000 0 0", out, jumped, halted);
        end
        #1 reset = 1'b0;
        for (int i = 1; i <= 3; i++) exp_q.push_back('{16'(i), 1'b0, 1'b0, "post_reset"});
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({out, jumped, halted} !== {e.pc, e.jmp, e.hlt}) begin
                n_fail++;
                $display("FAIL %s: out=%h jumped=%b halted=%b, required %h %b %b", e.tag, out, jumped, halted, e.pc, e.jmp, e.hlt);
            end
        end
    endtask

    task automatic test_cond_jump();
        logic [15:0] alu_v [4] = '{16'h0000, 16'h8001, 16'h8001, 16'h0001};
        logic [2:0]  j_v   [4] = '{3'b010, 3'b010, 3'b100, 3'b001};
        logic        zr_v  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic        ng_v  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] pc_v  [4] = '{16'h0100, 16'h0011, 16'h0100, 16'h0100};
        logic        jm_v  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            set_pc(16'h0010);
            aluout = alu_v[k]; j = j_v[k]; jaddr = 16'h0100; cinst = 1'b1;
            #1;
            n_cmp++;
            if ({zr, ng} !== {zr_v[k], ng_v[k]}) begin
                n_fail++;
                $display("FAIL flags[%0d]: zr=%b ng=%b, required %b %b", k, zr, ng, zr_v[k], ng_v[k]);
            end
            exp_q.push_back('{pc_v[k], jm_v[k], 1'b0, "cond_jump"});
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({out, jumped, halted} !== {e.pc, e.jmp, e.hlt}) begin
                n_fail++;
                $display("FAIL %s[%0d]: out=%h jumped=%b halted=%b, required %h %b %b", e.tag, k, out, jumped, halted, e.pc, e.jmp, e.hlt);
            end
            cinst = 1'b0; j = 3'b000; aluout = '0;
        end
    endtask

    task automatic test_wrap();
        set_pc(16'hFFFE);
        exp_q.push_back('{16'hFFFF, 1'b0, 1'b0, "wrap0"});
        exp_q.push_back('{16'h0000, 1'b0, 1'b0, "wrap1"});
        exp_q.push_back('{16'h0001, 1'b0, 1'b0, "wrap2"});
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({out, jumped, halted} !== {e.pc, e.jmp, e.hlt}) begin
                n_fail++;
                $display("FAIL %s: out=%h jumped=%b halted=%b, required %h %b %b", e.tag, out, jumped, halted, e.pc, e.jmp, e.hlt);
            end
        end
    endtask

    task automatic test_hold();
        set_pc(16'h0020);
        hold = 1'b1; cinst = 1'b1; j = 3'b111; jaddr = 16'h0300;
        // jumped from the preceding load is retained while stalled.
        exp_q.push_back('{16'h0020, 1'b1, 1'b0, "hold0"});
        exp_q.push_back('{16'h0020, 1'b1, 1'b0, "hold1"});
        exp_q.push_back('{16'h0300, 1'b1, 1'b0, "hold_release"});
        for (int k = 0; k < 3; k++) begin
            if (k == 2) hold = 1'b0;
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({out, jumped, halted} !== {e.pc, e.jmp, e.hlt}) begin
                n_fail++;
                $display("FAIL %s: out=%h jumped=%b halted=%b, required %h %b %b", e.tag, out, jumped, halted, e.pc, e.jmp, e.hlt);
            end
        end
        cinst = 1'b0; j = 3'b000;
    endtask

    task automatic test_halt();
        set_pc(16'h0040);
        cinst = 1'b1; j = 3'b111; jaddr = 16'h0040;
        exp_q.push_back('{16'h0040, 1'b1, 1'b1, "halt_entry"});
        for (int k = 0; k < 5; k++) exp_q.push_back('{16'h0040, 1'b0, 1'b1, "halt_frozen"});
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                jaddr = 16'h0500;
                hold  = k[0];
            end
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({out, jumped, halted} !== {e.pc, e.jmp, e.hlt}) begin
                n_fail++;
                $display("FAIL %s[%0d]: out=%h jumped=%b halted=%b, required %h %b %b", e.tag, k, out, jumped, halted, e.pc, e.jmp, e.hlt);
            end
        end
        hold = 1'b0; cinst = 1'b0; j = 3'b000;
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if ({out, jumped, halted} !== {16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_reset: out=%h jumped=%b halted=%b, required 0000 0 0", out, jumped, halted);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_cinst_gating();
        cinst = 1'b0; j = 3'b111; aluout = 16'h0000; jaddr = 16'h0600;
        exp_q.push_back('{16'h0001, 1'b0, 1'b0, "cinst_gate"});
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if ({out, jumped, halted} !== {e.pc, e.jmp, e.hlt}) begin
            n_fail++;
            $display("FAIL %s: out=%h jumped=%b halted=%b, required %h %b %b", e.tag, out, jumped, halted, e.pc, e.jmp, e.hlt);
        end
        j = 3'b000;
    endtask

    task automatic test_back_to_back();
        logic [15:0] tgt [3] = '{16'h0000, 16'h0050, 16'h0060};
        set_pc(16'h0007);
        // A jump to 0 from a non-zero PC is an ordinary jump.
        exp_q.push_back('{16'h0000, 1'b1, 1'b0, "jump_zero"});
        exp_q.push_back('{16'h0050, 1'b1, 1'b0, "b2b_0"});
        exp_q.push_back('{16'h0060, 1'b1, 1'b0, "b2b_1"});
        exp_q.push_back('{16'h0061, 1'b0, 1'b0, "b2b_inc"});
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                cinst = 1'b1; j = 3'b111; jaddr = tgt[k];
            end else begin
                cinst = 1'b0; j = 3'b000;
            end
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({out, jumped, halted} !== {e.pc, e.jmp, e.hlt}) begin
                n_fail++;
                $display("FAIL %s: out=%h jumped=%b halted=%b, required %h %b %b", e.tag, out, jumped, halted, e.pc, e.jmp, e.hlt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cond_jump();
        test_wrap();
        test_hold();
        test_halt();
        test_cinst_gating();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
